hazard_stall_unit: RTL and testbench

//  Stall/flush controller for the 5-stage pipeline; the counterpart of the forwarding path.

---
 rtl/hazard_stall_unit.sv | 139 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch/jump squashes,
// data-memory wait freezes with a sticky timeout, and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRd_EX,
  input  logic [4:0]       Rd_EX,
  input  logic [4:0]       Ra_ID,
  input  logic [4:0]       Rb_ID,
  input  logic             UseRa_ID,
  input  logic             UseRb_ID,
  input  logic             MemWr_ID,
  input  logic             BrTaken_EX,
  input  logic             Jump_ID,
  input  logic             MemReq_M,
  input  logic             MemReady,
  output logic             PCWr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_M_Wr,
  output logic             M_WB_Wr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StLuBubble, StMemWait, StErr} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic lu, freeze;
  logic pc_wr, if_id_wr, if_id_flush, id_ex_flush, ex_m_wr, m_wb_wr;

  // A store whose only match is its data operand (Rb) is served by store-data forwarding.
  assign lu = MemRd_EX & (Rd_EX != 5'd0) &
              ((UseRa_ID & (Ra_ID == Rd_EX)) | (UseRb_ID & (Rb_ID == Rd_EX) & ~MemWr_ID));
  assign freeze = MemReq_M & ~MemReady;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    pc_wr         = 1'b1;
    if_id_wr      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_m_wr       = 1'b1;
    m_wb_wr       = 1'b1;

    if (rst) begin
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      ex_m_wr       = 1'b0;
      m_wb_wr       = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      state_d       = StRun;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end else if (state_q == StErr) begin
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      ex_m_wr       = 1'b0;
      m_wb_wr       = 1'b0;
      mem_timeout_d = 1'b1;
    end else if (freeze) begin
      pc_wr    = 1'b0;
      if_id_wr = 1'b0;
      ex_m_wr  = 1'b0;
      m_wb_wr  = 1'b0;
      if (state_q == StMemWait) begin
        if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
          state_d       = StErr;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else begin
        state_d    = StMemWait;
        wait_cnt_d = WaitW'(1);
      end
    end else begin
      state_d    = StRun;
      wait_cnt_d = '0;
      if (BrTaken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu && (state_q != StLuBubble)) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_flush = 1'b1;
        state_d     = StLuBubble;
      end else if (Jump_ID) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if (!pc_wr && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign PCWr        = pc_wr;
  assign IF_ID_Wr    = if_id_wr;
  assign IF_ID_Flush = if_id_flush;
  assign ID_EX_Flush = id_ex_flush;
  assign EX_M_Wr     = ex_m_wr;
  assign M_WB_Wr     = m_wb_wr;
  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default and small timeout/counter) driven in
// lockstep, checked against a per-cycle hazard model, a vector table and directed sequences.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic       rst;
    logic       memrd;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       usera;
    logic       useb;
    logic       memwr;
    logic       br;
    logic       jmp;
    logic       memreq;
    logic       ready;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [5:0] exp;
  } vec_t;

  // Output packing: {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, EX_M_Wr, M_WB_Wr}
  localparam logic [5:0] ONorm  = 6'b110011;
  localparam logic [5:0] OLu    = 6'b000111;
  localparam logic [5:0] OBr    = 6'b111111;
  localparam logic [5:0] OJmp   = 6'b111011;
  localparam logic [5:0] OFrz   = 6'b000000;
  localparam logic [5:0] ORst   = 6'b001100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;
  logic [5:0]  o0, o1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic        mt0, mt1;

  hazard_stall_unit #(.MEM_TIMEOUT(64), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(cur.rst), .MemRd_EX(cur.memrd), .Rd_EX(cur.rd), .Ra_ID(cur.ra),
    .Rb_ID(cur.rb), .UseRa_ID(cur.usera), .UseRb_ID(cur.useb), .MemWr_ID(cur.memwr),
    .BrTaken_EX(cur.br), .Jump_ID(cur.jmp), .MemReq_M(cur.memreq), .MemReady(cur.ready),
    .PCWr(o0[5]), .IF_ID_Wr(o0[4]), .IF_ID_Flush(o0[3]), .ID_EX_Flush(o0[2]),
    .EX_M_Wr(o0[1]), .M_WB_Wr(o0[0]), .stall_cnt(cnt0), .mem_timeout(mt0)
  );

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(cur.rst), .MemRd_EX(cur.memrd), .Rd_EX(cur.rd), .Ra_ID(cur.ra),
    .Rb_ID(cur.rb), .UseRa_ID(cur.usera), .UseRb_ID(cur.useb), .MemWr_ID(cur.memwr),
    .BrTaken_EX(cur.br), .Jump_ID(cur.jmp), .MemReq_M(cur.memreq), .MemReady(cur.ready),
    .PCWr(o1[5]), .IF_ID_Wr(o1[4]), .IF_ID_Flush(o1[3]), .ID_EX_Flush(o1[2]),
    .EX_M_Wr(o1[1]), .M_WB_Wr(o1[0]), .stall_cnt(cnt1), .mem_timeout(mt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: consecutive frozen cycles, "last cycle was a load-use stall", error flag, count.
  int m_tmo [2] = '{64, 4};
  int m_max [2] = '{65535, 3};
  int m_frz [2] = '{0, 0};
  bit m_bub [2] = '{0, 0};
  bit m_err [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};

  logic [5:0] last_o [2];
  int         last_cnt [2];
  logic       last_mt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_lu(input in_t v);
    return v.memrd && (v.rd != 0) &&
           ((v.usera && (v.ra == v.rd)) || (v.useb && (v.rb == v.rd) && !v.memwr));
  endfunction

  task automatic model_out(input int k, input in_t v, output logic [5:0] o, output bit lu_stall);
    lu_stall = 1'b0;
    if (v.rst)                            o = ORst;
    else if (m_err[k])                    o = OFrz;
    else if (v.memreq && !v.ready)        o = OFrz;
    else if (v.br)                        o = OBr;
    else if (is_lu(v) && !m_bub[k]) begin o = OLu; lu_stall = 1'b1; end
    else if (v.jmp)                       o = OJmp;
    else                                  o = ONorm;
  endtask

  task automatic model_commit(input int k, input in_t v, input logic [5:0] o, input bit lu_stall);
    if (v.rst) begin
      m_frz[k] = 0; m_bub[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (!o[5] && m_cnt[k] < m_max[k]) m_cnt[k]++;
    if (m_err[k]) return;
    if (v.memreq && !v.ready) begin
      m_frz[k]++;
      m_bub[k] = 1'b0;
      if (m_frz[k] > m_tmo[k]) m_err[k] = 1'b1;
    end else begin
      m_frz[k] = 0;
      m_bub[k] = lu_stall;
    end
  endtask

  // Drive one cycle: inputs applied just after posedge, everything sampled at negedge.
  task automatic step(input in_t v);
    logic [5:0] eo [2];
    bit         ls [2];
    cur = v;
    #4;
    last_o[0] = o0;  last_o[1] = o1;
    last_cnt[0] = int'(cnt0); last_cnt[1] = int'(cnt1);
    last_mt[0] = mt0; last_mt[1] = mt1;
    for (int k = 0; k < 2; k++) begin
      model_out(k, v, eo[k], ls[k]);
      chk($sformatf("outs[%0d]", k), 32'(last_o[k]), 32'(eo[k]));
      chk($sformatf("stall_cnt[%0d]", k), last_cnt[k], m_cnt[k]);
      chk($sformatf("mem_timeout[%0d]", k), 32'(last_mt[k]), 32'(m_err[k]));
    end
    for (int k = 0; k < 2; k++) model_commit(k, v, eo[k], ls[k]);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t nop();
    in_t v = '0;
    return v;
  endfunction

  function automatic in_t rst_v();
    in_t v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic in_t lu_v();
    in_t v = '0;
    v.memrd = 1'b1; v.rd = 5'd5; v.usera = 1'b1; v.ra = 5'd5;
    return v;
  endfunction

  function automatic in_t frz_v();
    in_t v = '0;
    v.memreq = 1'b1;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    in_t v;
    int  saved;
    int  burst;

    cur = rst_v();
    @(posedge clk);
    #1;

    // Reset behaviour and first free-running cycle
    step(rst_v());
    chk("reset_outs", 32'(last_o[0]), 32'(ORst));
    step(nop());
    chk("post_reset_cnt", last_cnt[0], 0);
    chk("post_reset_outs", 32'(last_o[0]), 32'(ONorm));

    // Table of single-cycle decisions, each from a clean RUN state
    v = lu_v();                                          tbl.push_back('{"lu_ra", v, OLu});
    v = '0; v.memrd = 1; v.rd = 7; v.useb = 1; v.rb = 7; tbl.push_back('{"lu_rb", v, OLu});
    v = '0; v.memrd = 1; v.rd = 5; v.useb = 1; v.rb = 5; v.memwr = 1; v.usera = 1; v.ra = 2;
    tbl.push_back('{"store_data_only", v, ONorm});
    v = '0; v.memrd = 1; v.rd = 5; v.usera = 1; v.ra = 5; v.memwr = 1;
    tbl.push_back('{"store_addr_match", v, OLu});
    v = '0; v.memrd = 1; v.usera = 1;                    tbl.push_back('{"rd_zero", v, ONorm});
    v = '0; v.memrd = 1; v.rd = 3; v.rb = 3;             tbl.push_back('{"rb_unused", v, ONorm});
    v = '0; v.br = 1;                                    tbl.push_back('{"branch", v, OBr});
    v = lu_v(); v.br = 1;                                tbl.push_back('{"branch_over_lu", v, OBr});
    v = '0; v.jmp = 1;                                   tbl.push_back('{"jump", v, OJmp});
    v = lu_v(); v.jmp = 1;                               tbl.push_back('{"lu_over_jump", v, OLu});
    v = frz_v();                                         tbl.push_back('{"freeze", v, OFrz});
    v = frz_v(); v.br = 1; v.jmp = 1;                    tbl.push_back('{"freeze_over_br", v, OFrz});
    v = frz_v(); v.ready = 1;                            tbl.push_back('{"req_ready", v, ONorm});
    foreach (tbl[i]) begin
      step(rst_v());
      step(tbl[i].v);
      chk(tbl[i].name, 32'(last_o[0]), 32'(tbl[i].exp));
    end

    // Load-use: one bubble, then advance; a repeated lu in the bubble cycle is ignored
    step(rst_v());
    step(lu_v());
    chk("lu_stall", 32'(last_o[0]), 32'(OLu));
    step(lu_v());
    chk("lu_bubble_ignores_lu", 32'(last_o[0]), 32'(ONorm));
    chk("lu_cnt", last_cnt[0], 1);

    // Branch with lu: no bubble, counter unchanged
    step(nop());
    saved = last_cnt[0];
    v = lu_v(); v.br = 1;
    step(v);
    step(lu_v());
    chk("br_lu_no_bubble", 32'(last_o[0]), 32'(OLu));
    chk("br_lu_cnt", last_cnt[0], saved);

    // Three wait cycles then ready
    step(rst_v());
    for (int i = 0; i < 3; i++) begin
      step(frz_v());
      chk("wait_frozen", 32'(last_o[0]), 32'(OFrz));
    end
    v = frz_v(); v.ready = 1;
    step(v);
    chk("wait_advance", 32'(last_o[0]), 32'(ONorm));
    step(nop());
    chk("wait_cnt3", last_cnt[0], 3);

    // Timeout on the small instance, then reset recovery
    step(rst_v());
    for (int i = 0; i < 5; i++) step(frz_v());
    step(nop());
    chk("timeout_flag", 32'(last_mt[1]), 32'd1);
    chk("err_frozen", 32'(last_o[1]), 32'(OFrz));
    chk("big_not_err", 32'(last_o[0]), 32'(ONorm));
    step(rst_v());
    step(nop());
    chk("err_cleared", 32'(last_mt[1]), 32'd0);
    chk("err_run", 32'(last_o[1]), 32'(ONorm));

    // Saturation of the 2-bit counter after five stalls
    step(rst_v());
    for (int i = 0; i < 5; i++) begin
      step(lu_v());
      step(nop());
    end
    chk("sat_small", last_cnt[1], 3);
    chk("sat_big", last_cnt[0], 5);

    // Randomized run against the model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 59) == 0);
      v.memrd = $urandom_range(0, 1);
      v.rd    = 5'($urandom_range(0, 3));
      v.ra    = 5'($urandom_range(0, 3));
      v.rb    = 5'($urandom_range(0, 3));
      v.usera = $urandom_range(0, 1);
      v.useb  = $urandom_range(0, 1);
      v.memwr = $urandom_range(0, 1);
      v.br    = ($urandom_range(0, 5) == 0);
      v.jmp   = ($urandom_range(0, 5) == 0);
      if (burst == 0 && $urandom_range(0, 25) == 0) burst = $urandom_range(3, 8);
      if (burst > 0) begin
        v.memreq = 1'b1;
        v.ready  = 1'b0;
        burst--;
      end else begin
        v.memreq = $urandom_range(0, 1);
        v.ready  = ($urandom_range(0, 2) != 0);
      end
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
